// File: rtl/ahblite_simple_master_pkg.sv
// -----------------------------------------------------------------------------
// ahblite_simple_master_pkg
// Shared AHB-Lite encodings and types for the simple single-transfer initiator.
//   - HTRANS / HSIZE / HBURST encodings used on the bus
//   - a_stage_t : the command fields held by the address stage
//   - addr_aligned_f : alignment rule between a byte address and a transfer size
// -----------------------------------------------------------------------------
package ahblite_simple_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Command captured at accept; drives the address phase and carries wdata
    // forward into the data phase.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } a_stage_t;

    localparam a_stage_t A_STAGE_RST = '{
        write: 1'b0,
        size:  2'b00,
        addr:  32'h0000_0000,
        wdata: 32'h0000_0000
    };

    // True when addr is naturally aligned for size; size 3 is never legal.
    function automatic logic addr_aligned_f(input logic [31:0] addr, input logic [1:0] size);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (addr[0] == 1'b0);
            2'd2:    ok = (addr[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahblite_simple_master_chk.sv
// -----------------------------------------------------------------------------
// ahblite_simple_master_chk
// Property checker for the command port and bus side of ahblite_simple_master.
// Flags illegal commands (size 3, misaligned address) at accept and any HTRANS
// value other than IDLE/NONSEQ.
// Ports: HCLK, HRESETn, cmd_valid, cmd_ready, cmd_addr[31:0], cmd_size[1:0],
//        HTRANS[1:0] -- all inputs.
// -----------------------------------------------------------------------------
module ahblite_simple_master_chk
    import ahblite_simple_master_pkg::*;
(
    input logic        HCLK,
    input logic        HRESETn,
    input logic        cmd_valid,
    input logic        cmd_ready,
    input logic [31:0] cmd_addr,
    input logic [1:0]  cmd_size,
    input logic [1:0]  HTRANS
);

    a_cmd_size_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (cmd_valid && cmd_ready) |-> (cmd_size != 2'd3));

    a_cmd_addr_aligned: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (cmd_valid && cmd_ready) |-> addr_aligned_f(cmd_addr, cmd_size));

    a_htrans_single_only: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ));

endmodule

// File: rtl/ahblite_simple_master.sv
// -----------------------------------------------------------------------------
// ahblite_simple_master
// AHB-Lite initiator turning a valid/ready command stream into NONSEQ/SINGLE
// transfers, one in-order response per command. The address phase of command
// N+1 overlaps the data phase of command N.
// Ports:
//   HCLK, HRESETn                 clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready combinational)
//   cmd_write, cmd_addr[31:0], cmd_size[1:0], cmd_wdata[31:0]  command fields
//   rsp_valid, rsp_err, rsp_rdata[31:0]                       response (registered)
//   HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA  AHB master outputs
//   HREADY, HRESP, HRDATA         AHB slave response inputs
// -----------------------------------------------------------------------------
module ahblite_simple_master
    import ahblite_simple_master_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
)
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA
);

    // Address stage
    a_stage_t    a_r;
    logic        a_vld_r;
    logic [1:0]  htrans_r;
    // Data stage
    logic        d_vld_r;
    logic        d_write_r;
    logic [31:0] d_wdata_r;
    // A command was cancelled by an ERROR and still owes its response
    logic        cancel_pend_r;
    // Response register
    logic        rsp_valid_r;
    logic        rsp_err_r;
    logic [31:0] rsp_rdata_r;

    logic        accept_s;
    logic        a_vld_nxt_s;
    logic        err_first_s;
    logic        cancel_s;
    logic        d_done_s;
    logic        cancel_rsp_s;
    logic        rsp_valid_nxt_s;
    logic        rsp_err_nxt_s;
    logic [31:0] rsp_rdata_nxt_s;

    // A new command may enter when the address slot is empty or is being
    // handed to the data stage without error, and never while a cancelled
    // command still waits for its response.
    assign cmd_ready    = (~a_vld_r | (HREADY & ~HRESP)) & ~cancel_pend_r;
    assign accept_s     = cmd_valid & cmd_ready;
    assign err_first_s  = d_vld_r & HRESP & ~HREADY;
    assign cancel_s     = err_first_s & a_vld_r;
    assign d_done_s     = d_vld_r & HREADY;
    // The errored transfer has retired once the data stage is empty again.
    assign cancel_rsp_s = cancel_pend_r & ~d_vld_r;

    // Next address-stage occupancy: cancel on first error cycle, otherwise
    // reload from the command port whenever the slot frees up.
    always_comb begin
        a_vld_nxt_s = a_vld_r;
        if (cancel_s) begin
            a_vld_nxt_s = 1'b0;
        end else if (~a_vld_r | HREADY) begin
            a_vld_nxt_s = accept_s;
        end else begin
            a_vld_nxt_s = a_vld_r;
        end
    end

    // Next response: data-stage completion and cancelled-command responses
    // are mutually exclusive because the latter needs an empty data stage.
    always_comb begin
        rsp_valid_nxt_s = 1'b0;
        rsp_err_nxt_s   = 1'b0;
        rsp_rdata_nxt_s = 32'h0000_0000;
        if (d_done_s) begin
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = HRESP;
            if (~d_write_r & ~HRESP) begin
                rsp_rdata_nxt_s = HRDATA;
            end else begin
                rsp_rdata_nxt_s = 32'h0000_0000;
            end
        end else if (cancel_rsp_s) begin
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = 1'b1;
        end else begin
            rsp_valid_nxt_s = 1'b0;
        end
    end

    // Address stage registers; HTRANS is registered alongside occupancy.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_vld_r  <= 1'b0;
            htrans_r <= HTRANS_IDLE;
            a_r      <= A_STAGE_RST;
        end else begin
            a_vld_r  <= a_vld_nxt_s;
            htrans_r <= a_vld_nxt_s ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (accept_s) begin
                a_r <= '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
            end
        end
    end

    // Data stage registers; advance whenever the bus is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_vld_r   <= 1'b0;
            d_write_r <= 1'b0;
            d_wdata_r <= 32'h0000_0000;
        end else if (HREADY) begin
            d_vld_r <= a_vld_r;
            if (a_vld_r) begin
                d_write_r <= a_r.write;
                d_wdata_r <= a_r.wdata;
            end
        end
    end

    // Cancel-pending flag: set when a queued address phase is dropped.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cancel_pend_r <= 1'b0;
        end else if (cancel_s) begin
            cancel_pend_r <= 1'b1;
        end else if (cancel_rsp_s) begin
            cancel_pend_r <= 1'b0;
        end
    end

    // Response register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;

    assign HADDR     = a_r.addr;
    assign HWRITE    = a_r.write;
    assign HSIZE     = {1'b0, a_r.size};
    assign HTRANS    = htrans_r;
    assign HWDATA    = d_wdata_r;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule
